cpu_io_responder: RTL and testbench

- Device-side responder to the CPU output/input interface.
- Each cycle it samples the CPU's OUT_DEVICE/OUT_DATA write bus and decodes device writes into four targets: a GPIO output register, a TX FIFO, an interrupt mask/clear and an input-select register.
- Drives the CPU's IN_DATA read word.
- Raises the CPU's ITR line from masked, sticky interrupt sources.

---
 rtl/cpu_io_responder.sv | 106 ++++++++++
 tb/tb_cpu_io_responder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_io_responder.sv
// Device-side responder for the CPU OUT/IN port: decodes device writes into GPIO, TX FIFO,
// interrupt mask/clear and read-select registers, and returns a registered read word plus ITR.
module cpu_io_responder #(
  parameter int FIFO_DEPTH = 8,
  parameter int FIFO_AW    = 3
) (
  input  logic        CPU_clock,
  input  logic        CPU_reset,
  input  logic [15:0] OUT_DEVICE,
  input  logic [15:0] OUT_DATA,
  output logic [15:0] IN_DATA,
  output logic        ITR,
  input  logic [15:0] GPIO_IN,
  output logic [15:0] GPIO_OUT,
  output logic [15:0] TX_DATA,
  output logic        TX_VALID,
  input  logic        TX_READY
);

  localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW + 1)'(FIFO_DEPTH);

  logic [15:0]        mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic [2:0]         mask, pending;
  logic [1:0]         in_sel;
  logic [15:0]        s1, s2, s3;

  logic        full, empty, pop, push_req, push_ok;
  logic [2:0]  set_bits, clr_bits;
  logic [3:0]  count4;
  logic [15:0] status, in_next;

  // TX handshake: an entry transfers on every edge where TX_VALID and TX_READY are both high;
  // TX_VALID/TX_DATA come straight from registers and hold until that transfer.
  assign full     = (count == DEPTH_C);
  assign empty    = (count == '0);
  assign TX_VALID = !empty;
  assign TX_DATA  = mem[rd_ptr];
  assign pop      = TX_VALID && TX_READY;
  assign push_req = (OUT_DEVICE == 16'd2);
  // A full FIFO can still take a push when the head leaves on the same edge.
  assign push_ok  = push_req && (!full || pop);

  assign set_bits = {(count == (FIFO_AW + 1)'(1)) && pop && !push_ok,
                     push_req && !push_ok,
                     s2 != s3};
  assign clr_bits = (OUT_DEVICE == 16'd4) ? OUT_DATA[2:0] : 3'b000;

  assign count4 = 4'(count);
  assign status = {4'b0000, count4, full, empty, mask, pending};

  always_comb begin
    in_next = s3;
    unique case (in_sel)
      2'd0: in_next = s3;
      2'd1: in_next = status;
      2'd2: in_next = GPIO_OUT;
      2'd3: in_next = TX_DATA;
      default: in_next = s3;
    endcase
  end

  always_ff @(posedge CPU_clock or posedge CPU_reset) begin
    if (CPU_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= OUT_DATA;
        wr_ptr      <= wr_ptr + FIFO_AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + FIFO_AW'(1);
      if (push_ok && !pop)      count <= count + (FIFO_AW + 1)'(1);
      else if (pop && !push_ok) count <= count - (FIFO_AW + 1)'(1);
    end
  end

  always_ff @(posedge CPU_clock or posedge CPU_reset) begin
    if (CPU_reset) begin
      GPIO_OUT <= '0;
      mask     <= '0;
      in_sel   <= '0;
      pending  <= '0;
      ITR      <= 1'b0;
      IN_DATA  <= '0;
      s1       <= '0;
      s2       <= '0;
      s3       <= '0;
    end else begin
      if (OUT_DEVICE == 16'd1) GPIO_OUT <= OUT_DATA;
      if (OUT_DEVICE == 16'd3) mask     <= OUT_DATA[2:0];
      if (OUT_DEVICE == 16'd5) in_sel   <= OUT_DATA[1:0];
      // Set is OR-ed after the clear so a coincident event is never lost.
      pending <= (pending & ~clr_bits) | set_bits;
      ITR     <= |(pending & mask);
      IN_DATA <= in_next;
      s1      <= GPIO_IN;
      s2      <= s1;
      s3      <= s2;
    end
  end

endmodule

// File: tb/tb_cpu_io_responder.sv
// Self-checking bench for cpu_io_responder: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a queue-based reference model.
module tb_cpu_io_responder;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] out_device = '0;
  logic [15:0] out_data   = '0;
  logic [15:0] gpio_in    = '0;
  logic        tx_ready   = 1'b0;
  logic [15:0] in_data, gpio_out, tx_data;
  logic        itr, tx_valid;

  int n_checks = 0;
  int n_pass   = 0;
  bit done     = 1'b0;

  cpu_io_responder #(.FIFO_DEPTH(DEPTH), .FIFO_AW(3)) dut (
    .CPU_clock (clk),
    .CPU_reset (rst),
    .OUT_DEVICE(out_device),
    .OUT_DATA  (out_data),
    .IN_DATA   (in_data),
    .ITR       (itr),
    .GPIO_IN   (gpio_in),
    .GPIO_OUT  (gpio_out),
    .TX_DATA   (tx_data),
    .TX_VALID  (tx_valid),
    .TX_READY  (tx_ready)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // reference model state
  logic [15:0] exp_q[$];
  logic [15:0] m_gpo, m_in, m_s1, m_s2, m_s3;
  logic [2:0]  m_mask, m_pend;
  logic [1:0]  m_sel;
  logic        m_itr, m_known;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic m_reset();
    exp_q.delete();
    m_gpo = '0; m_in = '0; m_s1 = '0; m_s2 = '0; m_s3 = '0;
    m_mask = '0; m_pend = '0; m_sel = '0; m_itr = 1'b0; m_known = 1'b1;
  endtask

  task automatic m_step(input logic [15:0] dev, input logic [15:0] data,
                        input logic rdy, input logic [15:0] gin);
    int cnt;
    logic pop, push, acc;
    logic [2:0] setb, clrb;
    logic [3:0] c4;
    cnt  = exp_q.size();
    pop  = (cnt != 0) && rdy;
    push = (dev == 16'd2);
    acc  = push && ((cnt < DEPTH) || pop);
    setb = {(cnt == 1) && pop && !acc, push && !acc, m_s2 != m_s3};
    clrb = (dev == 16'd4) ? data[2:0] : 3'b000;
    c4   = 4'(cnt);
    m_known = 1'b1;
    case (m_sel)
      2'd0: m_in = m_s3;
      2'd1: m_in = {4'b0000, c4, cnt == DEPTH, cnt == 0, m_mask, m_pend};
      2'd2: m_in = m_gpo;
      default: if (cnt != 0) m_in = exp_q[0]; else m_known = 1'b0;
    endcase
    m_itr  = |(m_pend & m_mask);
    m_pend = (m_pend & ~clrb) | setb;
    if (dev == 16'd1) m_gpo  = data;
    if (dev == 16'd3) m_mask = data[2:0];
    if (dev == 16'd5) m_sel  = data[1:0];
    if (pop) void'(exp_q.pop_front());
    if (acc) exp_q.push_back(data);
    m_s3 = m_s2; m_s2 = m_s1; m_s1 = gin;
  endtask

  // scoreboard: advance model at each edge, compare shortly after
  initial begin
    m_reset();
    forever begin
      @(posedge clk);
      if (rst) m_reset();
      else m_step(out_device, out_data, tx_ready, gpio_in);
      #2;
      if (!rst && !done) begin
        check("gpio_out", gpio_out, m_gpo);
        check("tx_valid", 16'(tx_valid), 16'(exp_q.size() != 0));
        if (exp_q.size() != 0) check("tx_data", tx_data, exp_q[0]);
        check("itr", 16'(itr), 16'(m_itr));
        if (m_known) check("in_data", in_data, m_in);
      end
    end
  end

  // driver tasks (called at a falling edge, return at a falling edge)
  task automatic wr(input logic [15:0] dev, input logic [15:0] data);
    out_device = dev;
    out_data   = data;
    @(negedge clk);
    out_device = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #1 rst = 1'b1;
    idle(2);
    rst = 1'b0;

    // reset state
    check("rst_gpio_out", gpio_out, 16'h0000);
    check("rst_itr", 16'(itr), 16'h0000);
    check("rst_tx_valid", 16'(tx_valid), 16'h0000);
    check("rst_in_data", in_data, 16'h0000);
    wr(16'd5, 16'd1); idle(1);
    check("rst_status", in_data, 16'h0040);

    // GPIO_OUT and readback
    wr(16'd1, 16'hA5C3);
    check("gpio_write", gpio_out, 16'hA5C3);
    wr(16'd5, 16'd2); idle(1);
    check("gpio_readback", in_data, 16'hA5C3);

    // fill, overflow, ITR from pending[1]
    wr(16'd3, 16'h0002);
    wr(16'd5, 16'h0001);
    for (int i = 1; i <= 8; i++) wr(16'd2, 16'(i * 16'h1111));
    wr(16'd2, 16'h9999);
    check("ovf_itr_before", 16'(itr), 16'h0000);
    idle(1);
    check("ovf_itr_after", 16'(itr), 16'h0001);
    check("ovf_status", in_data, 16'h0892);
    tx_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check("drain_data", tx_data, 16'(i * 16'h1111));
      @(negedge clk);
    end
    tx_ready = 1'b0;
    check("drain_empty", 16'(tx_valid), 16'h0000);
    idle(1);
    check("empty_event_status", in_data, 16'h0056);
    wr(16'd4, 16'h0007);

    // full with simultaneous push and pop
    for (int i = 1; i <= 8; i++) wr(16'd2, 16'h1000 + 16'(i));
    tx_ready = 1'b1;
    wr(16'd2, 16'hBEEF);
    tx_ready = 1'b0;
    idle(1);
    check("pushpop_status", in_data, 16'h0890);
    tx_ready = 1'b1;
    for (int i = 2; i <= 8; i++) begin
      check("pushpop_data", tx_data, 16'h1000 + 16'(i));
      @(negedge clk);
    end
    check("pushpop_last", tx_data, 16'hBEEF);
    @(negedge clk);
    tx_ready = 1'b0;
    check("pushpop_empty", 16'(tx_valid), 16'h0000);
    wr(16'd4, 16'h0007);

    // GPIO change detect
    wr(16'd3, 16'h0001);
    gpio_in = 16'h0001;
    idle(3);
    check("gpio_itr_e2", 16'(itr), 16'h0000);
    idle(1);
    check("gpio_itr_e3", 16'(itr), 16'h0001);
    wr(16'd4, 16'h0001);
    check("clr_itr_same", 16'(itr), 16'h0001);
    idle(1);
    check("clr_itr_drop", 16'(itr), 16'h0000);
    gpio_in = 16'h0000;
    idle(2);
    wr(16'd4, 16'h0001);
    idle(1);
    check("set_wins_status", in_data, 16'h0049);
    check("set_wins_itr", 16'(itr), 16'h0001);

    // ignored device codes
    wr(16'd7, 16'h1234);
    wr(16'hFFFF, 16'hFFFF);
    wr(16'd6, 16'h5555);
    idle(1);
    check("ignored_status", in_data, 16'h0049);
    check("ignored_gpio_out", gpio_out, 16'hA5C3);
    wr(16'd4, 16'h0007);

    // mid-operation reset discards FIFO; nonzero GPIO at release raises pending[0]
    for (int i = 0; i < 3; i++) wr(16'd2, 16'(16'h0100 + i));
    rst = 1'b1;
    gpio_in = 16'h00F0;
    #1;
    check("midrst_tx_valid", 16'(tx_valid), 16'h0000);
    idle(2);
    rst = 1'b0;
    idle(4);
    wr(16'd5, 16'h0001); idle(1);
    check("release_status", in_data, 16'h0041);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      int r;
      r = $urandom_range(0, 11);
      if (r >= 8 && r <= 10) out_device = 16'd2;
      else if (r == 11)      out_device = ($urandom_range(0, 1) != 0) ? 16'hFFFF : 16'd0;
      else                   out_device = 16'(r);
      out_data = 16'($urandom);
      tx_ready = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 15) == 0) gpio_in = 16'($urandom);
      @(negedge clk);
    end
    out_device = '0;
    tx_ready   = 1'b0;
    idle(2);

    done = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
